// File: rtl/gate_bist_pkg.sv
// Shared types, polynomial constants and next-state helpers for the gate BIST controller.
// Pure declarations; no timing of its own.
// No flow control; the helpers are combinational.
package gate_bist_pkg;

  localparam int BIST_IN_W  = 22;
  localparam int BIST_OUT_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } bist_state_t;

  // x^22 + x^21 + 1: the feedback bit is the XOR of the two top stages.
  localparam logic [BIST_IN_W-1:0]  LFSR_TAPS = 22'h30_0000;
  // x^10 + x^7 + 1: the shifted-out bit is fed back into stages 0 and 7.
  localparam logic [BIST_OUT_W-1:0] MISR_TAPS = 10'h081;

  function automatic logic [BIST_IN_W-1:0] lfsr_next(input logic [BIST_IN_W-1:0] cur);
    return {cur[BIST_IN_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

  function automatic logic [BIST_OUT_W-1:0] misr_next(input logic [BIST_OUT_W-1:0] sig,
                                                      input logic [BIST_OUT_W-1:0] resp);
    logic [BIST_OUT_W-1:0] fb;
    fb = sig[BIST_OUT_W-1] ? MISR_TAPS : '0;
    return {sig[BIST_OUT_W-2:0], 1'b0} ^ fb ^ resp;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting gate-model responses.
// One cycle: sig reflects a clear or a compaction on the edge after clr/en.
// No backpressure; clr has priority over en, idle when neither is set.
module bist_misr
  import gate_bist_pkg::*;
#(
  parameter int OUT_W = BIST_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] resp,
  output logic [OUT_W-1:0] sig
);

  // Signature register: cleared at run start, folds in one response per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= misr_next(sig, resp);
    end
  end

endmodule

// File: rtl/gate_bist_controller.sv
// LFSR pattern generator + MISR compactor driving a combinational gate model.
// Each pattern held SETTLE_CYC cycles then captured; run = PAT_COUNT*(SETTLE_CYC+1) busy cycles + 1 done cycle.
// No backpressure; start ignored while busy or in DONE, abort returns to IDLE without a done pulse.
module gate_bist_controller
  import gate_bist_pkg::*;
#(
  parameter int IN_W       = BIST_IN_W,
  parameter int OUT_W      = BIST_OUT_W,
  parameter int PAT_COUNT  = 1024,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  seed,
  output logic [IN_W-1:0]  pat_o,
  input  logic [OUT_W-1:0] resp_i,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature,
  output logic [15:0]      pat_idx
);

  localparam logic [15:0] PAT_LAST    = 16'(PAT_COUNT);
  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  bist_state_t state, state_nxt;
  logic [3:0]  settle;
  logic        load_run;    // start accepted: seed pattern, clear signature/index
  logic        settle_dec;  // still waiting for the gate model to settle
  logic        capture;     // fold resp_i into the signature this edge
  logic        advance;     // step the LFSR to the next pattern
  logic        last_pat;

  assign last_pat = ((pat_idx + 16'd1) == PAT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode; abort beats the DONE transition, start beats abort in IDLE.
  always_comb begin
    state_nxt  = state;
    load_run   = 1'b0;
    settle_dec = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = APPLY;
          load_run  = 1'b1;
        end
      end
      APPLY: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (settle == 4'd0) begin
          state_nxt = CAPTURE;
        end else begin
          settle_dec = 1'b1;
        end
      end
      CAPTURE: begin
        busy    = 1'b1;
        capture = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_pat) begin
          state_nxt = DONE;
        end else begin
          state_nxt = APPLY;
          advance   = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pattern register, settle counter and capture index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_o   <= '0;
      settle  <= '0;
      pat_idx <= '0;
    end else if (load_run) begin
      // An all-zero seed would lock the LFSR at zero, so substitute all-ones.
      pat_o   <= (seed == '0) ? '1 : seed;
      settle  <= SETTLE_LOAD;
      pat_idx <= '0;
    end else begin
      if (settle_dec) begin
        settle <= settle - 4'd1;
      end
      if (capture && (pat_idx != PAT_LAST)) begin
        pat_idx <= pat_idx + 16'd1;
      end
      if (advance) begin
        pat_o  <= lfsr_next(pat_o);
        settle <= SETTLE_LOAD;
      end
    end
  end

  bist_misr #(
    .OUT_W (OUT_W)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_run),
    .en    (capture),
    .resp  (resp_i),
    .sig   (signature)
  );

endmodule
